// File: rtl/ram_arbiter.sv
// Two-requester arbiter/sequencer for a single-port synchronous RAM (read-before-write).
// Define RAM_ARB_FIXED_PRIORITY_EN for fixed priority (requester 0 wins ties); default is round-robin.
module ram_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state, state_d;
  logic                owner, owner_d;
  logic                grant;
  logic                tie_grant;
  logic                ack0_d, ack1_d, busy_d;
  logic                ram_read_d, ram_write_d;
  logic [ADDR_W-1:0]   ram_address_d;
  logic [DATA_W-1:0]   ram_data_in_d;
  logic [DATA_W-1:0]   rdata0_d, rdata1_d;

  assign state_dbg = state;

`ifdef RAM_ARB_FIXED_PRIORITY_EN
  assign tie_grant = 1'b0;
`else
  // Points at the requester granted most recently; reset to 1 so requester 0 wins the first tie.
  logic last_grant;

  always_ff @(posedge clock) begin
    if (clear) begin
      last_grant <= 1'b1;
    end else if (state == IDLE && (req0 || req1)) begin
      last_grant <= grant;
    end
  end

  assign tie_grant = ~last_grant;
`endif

  always_comb begin
    grant = 1'b0;
    if (req0 && req1) begin
      grant = tie_grant;
    end else if (req1) begin
      grant = 1'b1;
    end
  end

  always_comb begin
    state_d       = state;
    owner_d       = owner;
    ack0_d        = ack0;
    ack1_d        = ack1;
    busy_d        = busy;
    ram_read_d    = ram_read;
    ram_write_d   = ram_write;
    ram_address_d = ram_address;
    ram_data_in_d = ram_data_in;
    rdata0_d      = rdata0;
    rdata1_d      = rdata1;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_d       = ISSUE;
          owner_d       = grant;
          busy_d        = 1'b1;
          ram_write_d   = grant ? we1 : we0;
          ram_read_d    = grant ? ~we1 : ~we0;
          ram_address_d = grant ? addr1 : addr0;
          ram_data_in_d = grant ? wdata1 : wdata0;
        end
      end
      ISSUE: begin
        // RAM samples at the end of this cycle; address and data stay put.
        state_d     = WAIT;
        ram_read_d  = 1'b0;
        ram_write_d = 1'b0;
      end
      WAIT: begin
        state_d = RESP;
        if (owner) begin
          rdata1_d = ram_data_out;
          ack1_d   = 1'b1;
        end else begin
          rdata0_d = ram_data_out;
          ack0_d   = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= IDLE;
      owner       <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      busy        <= 1'b0;
      ram_read    <= 1'b0;
      ram_write   <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
      rdata0      <= '0;
      rdata1      <= '0;
    end else begin
      state       <= state_d;
      owner       <= owner_d;
      ack0        <= ack0_d;
      ack1        <= ack1_d;
      busy        <= busy_d;
      ram_read    <= ram_read_d;
      ram_write   <= ram_write_d;
      ram_address <= ram_address_d;
      ram_data_in <= ram_data_in_d;
      rdata0      <= rdata0_d;
      rdata1      <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model, timeline-based reference model, per-cycle compare and directed scenarios.
module tb_ram_arbiter;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
`ifdef RAM_ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              clock, clear;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1, busy, ram_read, ram_write;
  logic [DATA_W-1:0] rdata0, rdata1, ram_data_in, ram_data_out;
  logic [ADDR_W-1:0] ram_address;
  logic [1:0]        state_dbg;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .clear(clear),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .ram_read(ram_read), .ram_write(ram_write), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- RAM model (read-before-write) ----------------
  logic [DATA_W-1:0] mem   [0:511];
  logic [DATA_W-1:0] m_mem [0:511];

  always @(posedge clock) begin
    if (ram_read || ram_write) begin
      ram_data_out <= mem[ram_address];
      if (ram_write) mem[ram_address] <= ram_data_in;
    end
  end

  // ---------------- reference model: timeline from grant edge ----------------
  int                cyc = 0;
  bit                t_act = 1'b0;
  int                t0 = 0;
  bit                t_own, t_we, own;
  logic [ADDR_W-1:0] t_addr;
  logic [DATA_W-1:0] t_data, t_old;
  bit                m_last = 1'b1;
  logic              e_ack0 = 0, e_ack1 = 0, e_busy = 0, e_rd = 0, e_wr = 0;
  logic [ADDR_W-1:0] e_addr = '0;
  logic [DATA_W-1:0] e_din = '0, e_rdata0 = '0, e_rdata1 = '0;
  logic [DATA_W-1:0] exp_q[$];
  int                g_time_q[$];
  bit                g_own_q[$];

  always @(posedge clock) begin
    cyc++;
    // The RAM access one edge after the grant happens even if clear is high.
    if (t_act && cyc == t0 + 1) begin
      t_old = m_mem[t_addr];
      if (t_we) m_mem[t_addr] = t_data;
    end
    if (clear) begin
      t_act = 1'b0; m_last = 1'b1;
      e_ack0 = 0; e_ack1 = 0; e_busy = 0; e_rd = 0; e_wr = 0;
      e_addr = '0; e_din = '0; e_rdata0 = '0; e_rdata1 = '0;
    end else if (t_act) begin
      if (cyc == t0 + 1) begin
        e_rd = 0; e_wr = 0;
      end else if (cyc == t0 + 2) begin
        if (t_own) begin e_ack1 = 1; e_rdata1 = t_old; end
        else begin e_ack0 = 1; e_rdata0 = t_old; end
        exp_q.push_back(t_old);
      end else if (cyc == t0 + 3) begin
        e_ack0 = 0; e_ack1 = 0; e_busy = 0; t_act = 1'b0;
      end
    end else if (req0 || req1) begin
      if (req0 && req1) own = FIXED ? 1'b0 : ~m_last;
      else own = req1;
      m_last = own;
      t_own  = own;
      t_we   = own ? we1 : we0;
      t_addr = own ? addr1 : addr0;
      t_data = own ? wdata1 : wdata0;
      t_act  = 1'b1;
      t0     = cyc;
      e_rd = ~t_we; e_wr = t_we; e_addr = t_addr; e_din = t_data; e_busy = 1;
      g_own_q.push_back(own);
      g_time_q.push_back(cyc);
    end
  end

  // ---------------- per-cycle compare / scoreboard ----------------
  logic [DATA_W-1:0] sb_exp;
  always @(negedge clock) begin
    if (cyc > 0) begin
      check("ack0", 32'(ack0), 32'(e_ack0));
      check("ack1", 32'(ack1), 32'(e_ack1));
      check("busy", 32'(busy), 32'(e_busy));
      check("ram_read", 32'(ram_read), 32'(e_rd));
      check("ram_write", 32'(ram_write), 32'(e_wr));
      check("ram_address", 32'(ram_address), 32'(e_addr));
      check("ram_data_in", ram_data_in, e_din);
      check("rdata0", rdata0, e_rdata0);
      check("rdata1", rdata1, e_rdata1);
      if (ack0 || ack1) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL ack_unexpected: got ack0=%b ack1=%b expected no ack at t=%0t", ack0, ack1, $time);
        end else begin
          sb_exp = exp_q.pop_front();
          check("ack_data", ack1 ? rdata1 : rdata0, sb_exp);
        end
      end
    end
  end

  // Counters sample the cycle that just ended.
  int rd_cnt = 0, ack0_cnt = 0, ack1_cnt = 0, both_cnt = 0;
  always @(posedge clock) begin
    if (ram_read) rd_cnt++;
    if (ack0) ack0_cnt++;
    if (ack1) ack1_cnt++;
    if (ack0 && ack1) both_cnt++;
  end

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic txn(input bit p, input bit we, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d, input bit keep,
                     output logic [DATA_W-1:0] rd, output int lat);
    bit done;
    if (p) begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
    else begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    lat = 0; rd = '0; done = 0;
    for (int i = 1; i <= 12 && !done; i++) begin
      @(negedge clock);
      if (p ? ack1 : ack0) begin
        lat = i; rd = p ? rdata1 : rdata0; done = 1;
      end
    end
    if (!done) begin
      n_vec++; n_bad++;
      $display("FAIL txn_timeout: got no ack on port %0d expected ack within 12 cycles", p);
    end
    if (!keep) begin
      if (p) req1 = 0; else req0 = 0;
    end
  endtask

  task automatic tie(input logic [ADDR_W-1:0] a, output bit first,
                     output logic [DATA_W-1:0] r0, output logic [DATA_W-1:0] r1);
    bit got0, got1;
    req0 = 1; we0 = 0; addr0 = a;
    req1 = 1; we1 = 0; addr1 = a;
    got0 = 0; got1 = 0; first = 0; r0 = '0; r1 = '0;
    for (int i = 0; i < 20 && !(got0 && got1); i++) begin
      @(negedge clock);
      if (ack0 && !got0) begin
        if (!got1) first = 0;
        got0 = 1; r0 = rdata0; req0 = 0;
      end
      if (ack1 && !got1) begin
        if (!got0) first = 1;
        got1 = 1; r1 = rdata1; req1 = 0;
      end
    end
    if (!(got0 && got1)) begin
      n_vec++; n_bad++;
      $display("FAIL tie_timeout: got ack0=%b ack1=%b expected both acks", got0, got1);
      req0 = 0; req1 = 0;
    end
  endtask

  // ---------------- directed scenarios ----------------
  logic [DATA_W-1:0] rd, r0, r1;
  int                lat, g0;
  bit                first;
  bit                order[$];

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'hA500_0000 | i;
    mem[149] = 32'h0000_0022;
    mem[0]   = 32'h0100_0095;
    mem[7]   = 32'h0000_0707;
    mem[3]   = 32'h3333_3333;
    for (int i = 0; i < 512; i++) m_mem[i] = mem[i];
    ram_data_out = '0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    clear = 1;
    repeat (3) @(negedge clock);
    clear = 0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", {30'd0, ack1, ack0}, 32'd0);
    check("rst_ram_ctl", {30'd0, ram_write, ram_read}, 32'd0);
    check("rst_ram_address", 32'(ram_address), 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    @(negedge clock);

    // Scenario 1: single read by requester 0
    rd_cnt = 0; ack1_cnt = 0;
    txn(0, 0, 9'd149, '0, 0, rd, lat);
    check("s1_latency", 32'(lat), 32'd3);
    check("s1_rdata0", rd, 32'h0000_0022);
    repeat (3) @(negedge clock);
    check("s1_ram_read_cycles", 32'(rd_cnt), 32'd1);
    check("s1_ack1_quiet", 32'(ack1_cnt), 32'd0);

    // Scenario 2: write then read back on requester 1, back to back
    g0 = g_time_q.size();
    txn(1, 1, 9'd7, 32'hDEAD_BEEF, 1, rd, lat);
    check("s2_write_old", rd, 32'h0000_0707);
    txn(1, 0, 9'd7, '0, 0, rd, lat);
    check("s2_read_back", rd, 32'hDEAD_BEEF);
    if (g_time_q.size() >= g0 + 2) check("s2_grant_spacing", 32'(g_time_q[g0+1] - g_time_q[g0]), 32'd4);
    else check("s2_grant_count", 32'(g_time_q.size() - g0), 32'd2);
    repeat (2) @(negedge clock);

    // Scenario 3: simultaneous ties
    tie(9'd0, first, r0, r1);
    check("s3_tie1_first", 32'(first), 32'd0);
    check("s3_rdata0", r0, 32'h0100_0095);
    check("s3_rdata1", r1, 32'h0100_0095);
    repeat (2) @(negedge clock);
    txn(0, 0, 9'd149, '0, 0, rd, lat);
    repeat (2) @(negedge clock);
    tie(9'd0, first, r0, r1);
    check("s3_tie2_first", 32'(first), FIXED ? 32'd0 : 32'd1);
    repeat (2) @(negedge clock);

    // Scenario 4: both held high
    both_cnt = 0;
    order.delete();
    req0 = 1; we0 = 0; addr0 = 9'd149;
    req1 = 1; we1 = 0; addr1 = 9'd0;
    for (int i = 0; i < 40 && order.size() < 4; i++) begin
      @(negedge clock);
      if (ack0) order.push_back(1'b0);
      if (ack1) order.push_back(1'b1);
    end
    req0 = 0; req1 = 0;
    check("s4_grant_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4 && i < order.size(); i++)
      check("s4_grant_order", 32'(order[i]), FIXED ? 32'd0 : ((i % 2 == 0) ? 32'd1 : 32'd0));
    repeat (3) @(negedge clock);
    check("s4_ack_overlap", 32'(both_cnt), 32'd0);

    // Scenario 5: clear during ISSUE of a write
    ack0_cnt = 0;
    req0 = 1; we0 = 1; addr0 = 9'd3; wdata0 = 32'h1234_5678;
    @(negedge clock);
    clear = 1; req0 = 0;
    @(negedge clock);
    clear = 0;
    check("s5_busy", 32'(busy), 32'd0);
    check("s5_ram_ctl", {30'd0, ram_write, ram_read}, 32'd0);
    check("s5_ram_address", 32'(ram_address), 32'd0);
    check("s5_ram_data_in", ram_data_in, 32'd0);
    check("s5_rdata0", rdata0, 32'd0);
    repeat (4) @(negedge clock);
    check("s5_no_ack", 32'(ack0_cnt), 32'd0);
    txn(0, 0, 9'd3, '0, 0, rd, lat);
    check("s5_write_committed", rd, 32'h1234_5678);
    repeat (2) @(negedge clock);

    // Scenario 6: clear during WAIT of a read
    ack1_cnt = 0;
    req1 = 1; we1 = 0; addr1 = 9'd149;
    repeat (2) @(negedge clock);
    clear = 1; req1 = 0;
    @(negedge clock);
    clear = 0;
    check("s6_busy", 32'(busy), 32'd0);
    check("s6_rdata1", rdata1, 32'd0);
    repeat (3) @(negedge clock);
    check("s6_no_ack", 32'(ack1_cnt), 32'd0);
    txn(1, 0, 9'd0, '0, 0, rd, lat);
    check("s6_new_latency", 32'(lat), 32'd3);
    check("s6_new_rdata1", rd, 32'h0100_0095);

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end within 200000 time units");
    $fatal(1);
  end

endmodule
